// File: rtl/sprite_draw_scheduler_pkg.sv
// rtl/sprite_draw_scheduler_pkg.sv - shared types and widths for the sprite draw scheduler
// Purpose: FSM state encoding, VGA plot port widths and a small constant helper.
// Ports: none (package).
package sprite_draw_scheduler_pkg;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAW      = 3'd1,
    ST_DRAW_GAP  = 3'd2,
    ST_HOLD      = 3'd3,
    ST_ERASE     = 3'd4,
    ST_ERASE_GAP = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sprite_pixel_mux.sv
// rtl/sprite_pixel_mux.sv - combinational select of one sprite's x/y/colour slice
// Purpose: picks sprite idx out of the packed per-sprite coordinate/colour buses.
// Ports:
//   idx        in   index of the sprite to forward
//   spr_x/y/colour in packed per-sprite buses, sprite i in slice i
//   x/y/colour out  selected slice (0 when idx is out of range)
module sprite_pixel_mux
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int IDX_W       = 2
) (
  input  logic [IDX_W-1:0]                idx,
  input  logic [X_W*NUM_SPRITES-1:0]      spr_x,
  input  logic [Y_W*NUM_SPRITES-1:0]      spr_y,
  input  logic [COLOUR_W*NUM_SPRITES-1:0] spr_colour,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour
);

  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (idx == IDX_W'(i)) begin
        x      = spr_x[i*X_W +: X_W];
        y      = spr_y[i*Y_W +: Y_W];
        colour = spr_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - frame pacer driving draw/erase requests to sprite drawers
// Purpose: draws every sprite in turn (waiting for finish or a timeout), holds the frame,
//   erases every sprite for a fixed time, then repeats while enable is high. The active
//   sprite's x/y/colour is registered onto the single VGA plot port.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              run frames; dropping it lets the current frame finish, then idles
//   finish, collision   per-sprite draw-complete pulse and collision level
//   spr_x/y/colour      packed per-sprite position and colour
//   draw_signal, erase_signal  one-hot request levels
//   vga_x/y/colour, plot       registered plot port
//   hit_mask            sticky collision flags, cleared when a draw pass starts
//   frame_done          one-cycle pulse at the end of each erase pass
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES  = 4,
  parameter int FRAME_TICKS  = 833333,
  parameter int ERASE_CYCLES = 44,
  parameter int DRAW_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_SPRITES-1:0]          finish,
  input  logic [NUM_SPRITES-1:0]          collision,
  input  logic [X_W*NUM_SPRITES-1:0]      spr_x,
  input  logic [Y_W*NUM_SPRITES-1:0]      spr_y,
  input  logic [COLOUR_W*NUM_SPRITES-1:0] spr_colour,
  output logic [NUM_SPRITES-1:0]          draw_signal,
  output logic [NUM_SPRITES-1:0]          erase_signal,
  output logic [X_W-1:0]                  vga_x,
  output logic [Y_W-1:0]                  vga_y,
  output logic [COLOUR_W-1:0]             vga_colour,
  output logic                            plot,
  output logic [NUM_SPRITES-1:0]          hit_mask,
  output logic                            frame_done
);

  localparam int CNT_W = $clog2(max3(FRAME_TICKS, ERASE_CYCLES, DRAW_TIMEOUT) + 1);
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(DRAW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_SPRITES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_SPRITES-1:0]  hit_mask_q, hit_mask_d;
  logic [X_W-1:0]          vga_x_q, vga_x_d;
  logic [Y_W-1:0]          vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]     vga_colour_q, vga_colour_d;
  logic                    plot_q, plot_d;
  logic                    last_sprite;
  logic                    draw_pass_start;

  sprite_pixel_mux #(
    .NUM_SPRITES (NUM_SPRITES),
    .IDX_W       (IDX_W)
  ) u_pixel_mux (
    .idx        (idx_q),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_colour (spr_colour),
    .x          (vga_x_d),
    .y          (vga_y_d),
    .colour     (vga_colour_d)
  );

  assign last_sprite     = (idx_q == IDX_LAST);
  assign draw_pass_start = (state_q == ST_DRAW) && (idx_q == '0) && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_DRAW;
          idx_d   = '0;
        end
      end
      ST_DRAW: begin
        // A finish coinciding with the timeout count is just a normal exit.
        if (finish[idx_q] || (cnt_q == DRAW_LAST)) state_d = ST_DRAW_GAP;
      end
      ST_DRAW_GAP: begin
        if (last_sprite) begin
          idx_d   = '0;
          state_d = ST_HOLD;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_DRAW;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_ERASE;
      end
      ST_ERASE: begin
        if (cnt_q == ERASE_LAST) state_d = ST_ERASE_GAP;
      end
      ST_ERASE_GAP: begin
        if (last_sprite) begin
          idx_d      = '0;
          frame_done = 1'b1;
          state_d    = enable ? ST_DRAW : ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_ERASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // Every state starts counting from zero; IDLE never needs the counter.
    if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_d = '0;
    else                                                cnt_d = cnt_q + CNT_W'(1);

    // Clear-then-accumulate keeps a collision that lands on the clearing cycle.
    hit_mask_d = draw_pass_start ? collision : (hit_mask_q | collision);

    // plot follows the registered mux, so it reflects the previous cycle's state.
    plot_d = (state_q == ST_DRAW) || (state_q == ST_ERASE);
  end

  always_comb begin
    draw_signal  = '0;
    erase_signal = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      draw_signal[i]  = (state_q == ST_DRAW)  && (idx_q == IDX_W'(i));
      erase_signal[i] = (state_q == ST_ERASE) && (idx_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      hit_mask_q   <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      hit_mask_q   <= hit_mask_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign hit_mask   = hit_mask_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - self-checking bench for sprite_draw_scheduler
module tb_sprite_draw_scheduler;

  localparam int N  = 4;
  localparam int FT = 20;
  localparam int EC = 44;
  localparam int DT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  finish;
  logic [3:0]  collision;
  logic [35:0] spr_x;
  logic [31:0] spr_y;
  logic [11:0] spr_colour;
  logic [3:0]  draw_signal;
  logic [3:0]  erase_signal;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic [3:0]  hit_mask;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_draw  = '0;
  logic [3:0] exp_erase = '0;
  logic       exp_fd    = 1'b0;
  bit         model_on  = 1'b0;
  bit   [3:0] never_finish = '0;

  int dr_run[4], er_run[4], dr_last[4], er_last[4];
  int fd_count = 0;

  sprite_draw_scheduler #(
    .NUM_SPRITES  (N),
    .FRAME_TICKS  (FT),
    .ERASE_CYCLES (EC),
    .DRAW_TIMEOUT (DT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .finish       (finish),
    .collision    (collision),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .spr_colour   (spr_colour),
    .draw_signal  (draw_signal),
    .erase_signal (erase_signal),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .plot         (plot),
    .hit_mask     (hit_mask),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle of the expected request timeline; called just after a rising edge.
  task automatic cyc(input logic [3:0] d, input logic [3:0] e, input logic f);
    exp_draw  = d;
    exp_erase = e;
    exp_fd    = f;
    model_on  = 1'b1;
    @(posedge clk);
  endtask

  // Expected frame: draw each sprite (44 cycles when it finishes, 64 on timeout) with a
  // 1-cycle gap, FT quiet cycles, erase each for EC cycles with a 1-cycle gap.
  task automatic run_frame(input bit f1, input bit hclr, input bit drop, input bit abort);
    for (int i = 0; i < N; i++) begin
      int dur;
      dur = never_finish[i] ? DT : 44;
      for (int k = 0; k < dur; k++) begin
        cyc(4'(1 << i), 4'b0000, 1'b0);
        if (hclr && i == 0 && k == 2) begin
          #1 chk("hit_cleared", hit_mask, 4'b0000);
        end
        if (f1 && i == 1 && k == 2) begin
          #1;
          chk("vga_x_lit", vga_x, 9'd160);
          chk("vga_y_lit", vga_y, 8'd20);
          chk("vga_colour_lit", vga_colour, 3'd5);
          chk("plot_lit", plot, 1'b1);
        end
      end
      cyc(4'b0000, 4'b0000, 1'b0);
    end
    for (int t = 0; t < FT; t++) begin
      cyc(4'b0000, 4'b0000, 1'b0);
      if (f1 && t == 1)  begin #1 chk("hit_quiet", hit_mask, 4'b0000); end
      if (f1 && t == 4)  begin #1 collision = 4'b1000; end
      if (f1 && t == 5)  begin #1 collision = 4'b0000; end
      if (f1 && t == 10) begin #1 chk("hit_set", hit_mask, 4'b1000); end
      if (drop && t == 3) begin #1 enable = 1'b0; end
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < EC; k++) begin
        cyc(4'b0000, 4'(1 << i), 1'b0);
        if (abort && i == 1 && k == 10) return;
      end
      cyc(4'b0000, 4'b0000, logic'(i == N - 1));
    end
  endtask

  // Behavioural sprite drawers: finish pulses 43 cycles after the draw request rises.
  initial begin : drawers
    int dcnt[4];
    logic [3:0] dprev;
    finish = '0;
    dprev  = '0;
    for (int i = 0; i < 4; i++) dcnt[i] = 100;
    forever begin
      @(negedge clk);
      if (!reset) begin
        finish = '0;
        dprev  = '0;
        for (int i = 0; i < 4; i++) dcnt[i] = 100;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (draw_signal[i] && !dprev[i]) dcnt[i] = 0;
          else if (dcnt[i] < 100)          dcnt[i]++;
          finish[i] = (dcnt[i] == 43) && !never_finish[i];
        end
        dprev = draw_signal;
      end
    end
  end

  // Compare process: requests every cycle, plot/vga one cycle behind the active request.
  initial begin : compare
    logic [3:0]  prev_req;
    logic [35:0] px;
    logic [31:0] py;
    logic [11:0] pc;
    int pidx;
    prev_req = '0;
    px = '0; py = '0; pc = '0;
    for (int i = 0; i < 4; i++) begin
      dr_run[i] = 0; er_run[i] = 0; dr_last[i] = 0; er_last[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (!reset || !model_on) begin
        prev_req = '0;
      end else begin
        chk("draw_signal", draw_signal, exp_draw);
        chk("erase_signal", erase_signal, exp_erase);
        chk("frame_done", frame_done, exp_fd);
        chk("plot", plot, logic'(prev_req != 0));
        if (prev_req != 0) begin
          pidx = 0;
          for (int i = 0; i < 4; i++) if (prev_req[i]) pidx = i;
          chk("vga_x", vga_x, (px >> (9 * pidx)) & 36'h1ff);
          chk("vga_y", vga_y, (py >> (8 * pidx)) & 32'hff);
          chk("vga_colour", vga_colour, (pc >> (3 * pidx)) & 12'h7);
        end
        prev_req = exp_draw | exp_erase;
        px = spr_x; py = spr_y; pc = spr_colour;
      end
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin dr_run[i] = 0; er_run[i] = 0; end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (draw_signal[i]) dr_run[i]++;
          else if (dr_run[i] != 0) begin dr_last[i] = dr_run[i]; dr_run[i] = 0; end
          if (erase_signal[i]) er_run[i]++;
          else if (er_run[i] != 0) begin er_last[i] = er_run[i]; er_run[i] = 0; end
        end
        if (frame_done) fd_count++;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget at %0t", $time);
    $fatal(1);
  end

  initial begin : main
    reset      = 1'b0;
    enable     = 1'b0;
    collision  = '0;
    spr_x      = {9'd300, 9'd200, 9'd160, 9'd10};
    spr_y      = {8'd40, 8'd30, 8'd20, 8'd10};
    spr_colour = {3'd4, 3'd6, 3'd5, 3'd1};

    repeat (2) @(negedge clk);
    chk("rst_draw", draw_signal, 4'b0000);
    chk("rst_erase", erase_signal, 4'b0000);
    chk("rst_plot", plot, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_hit", hit_mask, 4'b0000);
    chk("rst_vga_x", vga_x, 9'd0);
    chk("rst_vga_y", vga_y, 8'd0);
    chk("rst_vga_colour", vga_colour, 3'd0);
    reset = 1'b1;
    @(posedge clk);
    repeat (3) cyc(4'b0000, 4'b0000, 1'b0);
    #1 enable = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("hit_held", hit_mask, 4'b1000);
    spr_x[8:0]   = 9'd77;
    never_finish = 4'b0100;

    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    never_finish = 4'b0000;
    chk("draw0_len", dr_last[0], 44);
    chk("draw2_timeout_len", dr_last[2], 64);
    chk("draw3_len", dr_last[3], 44);
    chk("erase3_len", er_last[3], 44);
    chk("frame_done_count2", fd_count, 2);

    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) cyc(4'b0000, 4'b0000, 1'b0);
    chk("frame_done_count3", fd_count, 3);

    #1 enable = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    model_on = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("async_erase", erase_signal, 4'b0000);
    chk("async_draw", draw_signal, 4'b0000);
    chk("async_plot", plot, 1'b0);
    chk("async_vga_x", vga_x, 9'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);

    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) cyc(4'b0000, 4'b0000, 1'b0);
    chk("post_reset_draw0_len", dr_last[0], 44);
    chk("frame_done_count4", fd_count, 4);
    model_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
